// File: rtl/ysyx_axi_arbiter.sv
// Arbiter from NR narrow read clients and one store client to a single 64-bit AXI4 master. Read and write each have their own FSM.
// YSYX_ARB_RR_EN selects round-robin read arbitration. Without it, the highest requester index wins.
module ysyx_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NR     = 2,
    parameter int IDW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [NR-1:0]        rd_valid_i,
    input  logic [NR*ADDR_W-1:0] rd_addr_i,
    input  logic [NR*8-1:0]      rd_strb_i,
    output logic [DATA_W-1:0]    rd_data_o,
    output logic [NR-1:0]        rd_done_o,
    output logic                 rd_err_o,

    input  logic                 wr_valid_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [DATA_W-1:0]    wr_data_i,
    input  logic [7:0]           wr_strb_i,
    output logic                 wr_done_o,
    output logic                 wr_err_o,

    input  logic                 io_master_awready_i,
    output logic                 io_master_awvalid_o,
    output logic [ADDR_W-1:0]    io_master_awaddr_o,
    output logic [IDW-1:0]       io_master_awid_o,
    output logic [7:0]           io_master_awlen_o,
    output logic [2:0]           io_master_awsize_o,
    output logic [1:0]           io_master_awburst_o,

    input  logic                 io_master_wready_i,
    output logic                 io_master_wvalid_o,
    output logic [63:0]          io_master_wdata_o,
    output logic [7:0]           io_master_wstrb_o,
    output logic                 io_master_wlast_o,

    output logic                 io_master_bready_o,
    input  logic                 io_master_bvalid_i,
    input  logic [1:0]           io_master_bresp_i,
    input  logic [IDW-1:0]       io_master_bid_i,

    input  logic                 io_master_arready_i,
    output logic                 io_master_arvalid_o,
    output logic [ADDR_W-1:0]    io_master_araddr_o,
    output logic [IDW-1:0]       io_master_arid_o,
    output logic [7:0]           io_master_arlen_o,
    output logic [2:0]           io_master_arsize_o,
    output logic [1:0]           io_master_arburst_o,

    output logic                 io_master_rready_o,
    input  logic                 io_master_rvalid_i,
    input  logic [1:0]           io_master_rresp_i,
    input  logic [63:0]          io_master_rdata_i,
    input  logic                 io_master_rlast_i,
    input  logic [IDW-1:0]       io_master_rid_i
);

    localparam int GW = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_AW_W, WR_B} wr_state_e;

    function automatic logic [2:0] strb_to_size(input logic [7:0] strb);
        logic [2:0] size;
        case (strb)
            8'h03:   size = 3'd1;
            8'h0f:   size = 3'd2;
            default: size = 3'd0;
        endcase
        return size;
    endfunction

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_e         rd_state_q, rd_state_d;
    logic [GW-1:0]     rd_gnt_q, rd_gnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        rd_strb_q, rd_strb_d;

    logic              arb_any;
    logic [GW-1:0]     arb_idx;
    logic [ADDR_W-1:0] arb_addr;
    logic [7:0]        arb_strb;
    logic              r_fire;
    logic [31:0]       rd_half;

`ifdef YSYX_ARB_RR_EN
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    always_comb begin : rd_arbiter
        arb_any  = 1'b0;
        arb_idx  = '0;
        arb_addr = '0;
        arb_strb = '0;
`ifdef YSYX_ARB_RR_EN
        // Scan a doubled request vector starting just past the last grant.
        for (int j = 0; j < 2*NR; j++) begin
            if (!arb_any && j > int'(rr_ptr_q) && rd_valid_i[j % NR]) begin
                arb_any  = 1'b1;
                arb_idx  = GW'(j % NR);
                arb_addr = rd_addr_i[(j % NR)*ADDR_W +: ADDR_W];
                arb_strb = rd_strb_i[(j % NR)*8 +: 8];
            end
        end
`else
        for (int i = 0; i < NR; i++) begin
            if (rd_valid_i[i]) begin
                arb_any  = 1'b1;
                arb_idx  = GW'(i);
                arb_addr = rd_addr_i[i*ADDR_W +: ADDR_W];
                arb_strb = rd_strb_i[i*8 +: 8];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            rd_gnt_q   <= '0;
            rd_addr_q  <= '0;
            rd_strb_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_strb_q  <= rd_strb_d;
        end
    end

`ifdef YSYX_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin : rd_fsm
        rd_state_d          = rd_state_q;
        rd_gnt_d            = rd_gnt_q;
        rd_addr_d           = rd_addr_q;
        rd_strb_d           = rd_strb_q;
`ifdef YSYX_ARB_RR_EN
        rr_ptr_d            = rr_ptr_q;
`endif
        io_master_arvalid_o = 1'b0;
        io_master_rready_o  = 1'b0;
        r_fire              = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (arb_any) begin
                    rd_gnt_d   = arb_idx;
                    rd_addr_d  = arb_addr;
                    rd_strb_d  = arb_strb;
`ifdef YSYX_ARB_RR_EN
                    rr_ptr_d   = arb_idx;
`endif
                    rd_state_d = RD_AR;
                end
            end
            RD_AR: begin
                io_master_arvalid_o = 1'b1;
                if (io_master_arready_i) begin
                    rd_state_d = RD_R;
                end
            end
            RD_R: begin
                io_master_rready_o = 1'b1;
                if (io_master_rvalid_i && io_master_rlast_i) begin
                    r_fire     = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        // Handshake outputs stay low for the whole reset cycle, not only after the edge.
        if (rst) begin
            io_master_arvalid_o = 1'b0;
            io_master_rready_o  = 1'b0;
            r_fire              = 1'b0;
        end
    end

    assign io_master_araddr_o  = rd_addr_q;
    assign io_master_arid_o    = IDW'(rd_gnt_q);
    assign io_master_arlen_o   = 8'd0;
    assign io_master_arsize_o  = strb_to_size(rd_strb_q);
    assign io_master_arburst_o = 2'b01;

    assign rd_half   = rd_addr_q[2] ? io_master_rdata_i[63:32] : io_master_rdata_i[31:0];
    assign rd_data_o = r_fire ? (rd_half >> {rd_addr_q[1:0], 3'b000}) : '0;
    assign rd_done_o = r_fire ? (NR'(1) << rd_gnt_q) : '0;
    assign rd_err_o  = r_fire && (io_master_rresp_i != 2'b00);

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wr_state_e         wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [7:0]        wr_strb_q, wr_strb_d;
    logic              aw_ok_q, aw_ok_d;
    logic              w_ok_q, w_ok_d;
    logic              aw_done, w_done;
    logic              b_fire;
    logic [31:0]       wr_shift;
    logic [3:0]        wr_strb_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            aw_ok_q    <= 1'b0;
            w_ok_q     <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            aw_ok_q    <= aw_ok_d;
            w_ok_q     <= w_ok_d;
        end
    end

    always_comb begin : wr_fsm
        wr_state_d          = wr_state_q;
        wr_addr_d           = wr_addr_q;
        wr_data_d           = wr_data_q;
        wr_strb_d           = wr_strb_q;
        aw_ok_d             = aw_ok_q;
        w_ok_d              = w_ok_q;
        aw_done             = 1'b0;
        w_done              = 1'b0;
        io_master_awvalid_o = 1'b0;
        io_master_wvalid_o  = 1'b0;
        io_master_bready_o  = 1'b0;
        b_fire              = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_valid_i) begin
                    wr_addr_d  = wr_addr_i;
                    wr_data_d  = wr_data_i;
                    wr_strb_d  = wr_strb_i;
                    aw_ok_d    = 1'b0;
                    w_ok_d     = 1'b0;
                    wr_state_d = WR_AW_W;
                end
            end
            WR_AW_W: begin
                io_master_awvalid_o = !aw_ok_q;
                io_master_wvalid_o  = !w_ok_q;
                aw_done = aw_ok_q || io_master_awready_i;
                w_done  = w_ok_q || io_master_wready_i;
                if (aw_done && w_done) begin
                    aw_ok_d    = 1'b0;
                    w_ok_d     = 1'b0;
                    wr_state_d = WR_B;
                end else begin
                    aw_ok_d = aw_done;
                    w_ok_d  = w_done;
                end
            end
            WR_B: begin
                io_master_bready_o = 1'b1;
                if (io_master_bvalid_i) begin
                    b_fire     = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        if (rst) begin
            io_master_awvalid_o = 1'b0;
            io_master_wvalid_o  = 1'b0;
            io_master_bready_o  = 1'b0;
            b_fire              = 1'b0;
        end
    end

    assign wr_shift   = wr_data_q << {wr_addr_q[1:0], 3'b000};
    assign wr_strb_lo = wr_strb_q[3:0] << wr_addr_q[1:0];

    assign io_master_awaddr_o  = wr_addr_q;
    assign io_master_awid_o    = '0;
    assign io_master_awlen_o   = 8'd0;
    assign io_master_awsize_o  = strb_to_size(wr_strb_q);
    assign io_master_awburst_o = 2'b01;
    assign io_master_wdata_o   = {wr_shift, wr_shift};
    assign io_master_wstrb_o   = wr_addr_q[2] ? {wr_strb_lo, 4'h0} : {4'h0, wr_strb_lo};
    assign io_master_wlast_o   = 1'b1;

    assign wr_done_o = b_fire;
    assign wr_err_o  = b_fire && (io_master_bresp_i != 2'b00);

    // Single-outstanding protocol: response IDs carry no information here.
    logic unused_resp_ids;
    assign unused_resp_ids = ^{io_master_rid_i, io_master_bid_i};

endmodule

// File: tb/tb_ysyx_axi_arbiter.sv
// Randomised bench for ysyx_axi_arbiter: an AXI slave driven from tasks and a byte-level reference model.
module tb_ysyx_axi_arbiter;
    localparam int NR  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IDW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR-1:0]    rd_valid;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*8-1:0]  rd_strb;
    logic [DW-1:0]    rd_data;
    logic [NR-1:0]    rd_done;
    logic             rd_err;
    logic             wr_valid;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [7:0]       wr_strb;
    logic             wr_done, wr_err;

    logic awready, awvalid, wready, wvalid, wlast, bready, bvalid;
    logic arready, arvalid, rready, rvalid, rlast;
    logic [AW-1:0]  awaddr, araddr;
    logic [IDW-1:0] awid, arid, bid, rid;
    logic [7:0]     awlen, arlen, wstrb;
    logic [2:0]     awsize, arsize;
    logic [1:0]     awburst, arburst, bresp, rresp;
    logic [63:0]    wdata, rdata;

    logic [AW-1:0] req_addr [NR];
    logic [7:0]    req_strb [NR];
    for (genvar gi = 0; gi < NR; gi++) begin : g_pack
        assign rd_addr[gi*AW +: AW] = req_addr[gi];
        assign rd_strb[gi*8 +: 8]   = req_strb[gi];
    end

    int n_vec = 0;
    int n_err = 0;
    int m_last = 0;

    ysyx_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NR(NR), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_strb_i(rd_strb),
        .rd_data_o(rd_data), .rd_done_o(rd_done), .rd_err_o(rd_err),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_strb_i(wr_strb),
        .wr_done_o(wr_done), .wr_err_o(wr_err),
        .io_master_awready_i(awready), .io_master_awvalid_o(awvalid), .io_master_awaddr_o(awaddr),
        .io_master_awid_o(awid), .io_master_awlen_o(awlen), .io_master_awsize_o(awsize),
        .io_master_awburst_o(awburst),
        .io_master_wready_i(wready), .io_master_wvalid_o(wvalid), .io_master_wdata_o(wdata),
        .io_master_wstrb_o(wstrb), .io_master_wlast_o(wlast),
        .io_master_bready_o(bready), .io_master_bvalid_i(bvalid), .io_master_bresp_i(bresp),
        .io_master_bid_i(bid),
        .io_master_arready_i(arready), .io_master_arvalid_o(arvalid), .io_master_araddr_o(araddr),
        .io_master_arid_o(arid), .io_master_arlen_o(arlen), .io_master_arsize_o(arsize),
        .io_master_arburst_o(arburst),
        .io_master_rready_o(rready), .io_master_rvalid_i(rvalid), .io_master_rresp_i(rresp),
        .io_master_rdata_i(rdata), .io_master_rlast_i(rlast), .io_master_rid_i(rid)
    );

    // ---------------- reference model ----------------
    function automatic int model_pick(input logic [NR-1:0] mask, input int last);
        int pick = -1;
`ifdef YSYX_ARB_RR_EN
        for (int d = 1; d <= NR; d++)
            if (pick < 0 && mask[(last + d) % NR]) pick = (last + d) % NR;
`else
        for (int i = NR - 1; i >= 0; i--)
            if (pick < 0 && mask[i]) pick = i;
`endif
        return pick;
    endfunction

    function automatic logic [2:0] model_size(input logic [7:0] strb);
        if (strb == 8'h0f) return 3'd2;
        if (strb == 8'h03) return 3'd1;
        return 3'd0;
    endfunction

    // Bytes addr[2:0].. of the beat, stopping at the end of the addressed 32-bit word.
    function automatic logic [31:0] model_rdata(input logic [31:0] addr, input logic [63:0] beat);
        logic [31:0] r = '0;
        int off = int'(addr[2:0]);
        for (int k = 0; k < 4; k++)
            if (int'(addr[1:0]) + k < 4) r[8*k +: 8] = beat[8*(off + k) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [31:0] addr, input logic [31:0] data);
        logic [63:0] w = '0;
        int a = int'(addr[1:0]);
        for (int lane = 0; lane < 8; lane++)
            if (lane % 4 >= a) w[8*lane +: 8] = data[8*(lane % 4 - a) +: 8];
        return w;
    endfunction

    function automatic logic [7:0] model_wstrb(input logic [31:0] addr, input logic [7:0] strb);
        logic [7:0] s = '0;
        int a = int'(addr[1:0]);
        for (int lane = 0; lane < 8; lane++)
            if ((lane / 4) == int'(addr[2]) && (lane % 4) >= a && strb[lane % 4 - a]) s[lane] = 1'b1;
        return s;
    endfunction

    function automatic logic [7:0] rand_strb();
        case ($urandom_range(0, 2))
            0:       return 8'h01;
            1:       return 8'h03;
            default: return 8'h0f;
        endcase
    endfunction

    // ---------------- slave-side transaction drivers ----------------
    task automatic run_read(input logic [NR-1:0] mask, input int ar_dly, input int r_dly,
                            input logic [63:0] beat, input logic [1:0] resp, output int lat);
        int g;
        int n;
        logic [AW-1:0] a_exp;
        logic [NR-1:0] oh;
        logic [31:0] d_exp;
        g = model_pick(mask, m_last);
        m_last = g;
        a_exp = req_addr[g];
        d_exp = model_rdata(a_exp, beat);
        oh = '0;
        oh[g] = 1'b1;
        lat = 0;
        n = 0;
        do begin
            @(posedge clk); #1; lat++; n++;
        end while (arvalid !== 1'b1 && n < 50);
        n_vec++;
        if (arvalid !== 1'b1) begin
            n_err++; $display("FAIL rd_ar_timeout: arvalid=%b want 1", arvalid); return;
        end
        n_vec++;
        if (arid !== IDW'(g)) begin n_err++; $display("FAIL rd_arid: got %0d want %0d", arid, g); end
        n_vec++;
        if (araddr !== a_exp) begin n_err++; $display("FAIL rd_araddr: got %h want %h", araddr, a_exp); end
        n_vec++;
        if (arsize !== model_size(req_strb[g])) begin
            n_err++; $display("FAIL rd_arsize: got %0d want %0d", arsize, model_size(req_strb[g]));
        end
        n_vec++;
        if ({arlen, arburst} !== {8'h00, 2'b01}) begin
            n_err++; $display("FAIL rd_arlen_burst: got %h/%b want 00/01", arlen, arburst);
        end
        for (int i = 0; i < ar_dly; i++) begin @(posedge clk); #1; lat++; end
        n_vec++;
        if (arvalid !== 1'b1 || araddr !== a_exp) begin
            n_err++; $display("FAIL rd_ar_hold: arvalid=%b araddr=%h want 1/%h", arvalid, araddr, a_exp);
        end
        arready = 1'b1;
        @(posedge clk); #1; lat++;
        arready = 1'b0;
        n = 0;
        while (rready !== 1'b1 && n < 50) begin @(posedge clk); #1; lat++; n++; end
        n_vec++;
        if (rready !== 1'b1 || arvalid !== 1'b0) begin
            n_err++; $display("FAIL rd_r_phase: rready=%b arvalid=%b want 1/0", rready, arvalid); return;
        end
        for (int i = 0; i < r_dly; i++) begin @(posedge clk); #1; lat++; end
        n_vec++;
        if (rd_done !== '0) begin n_err++; $display("FAIL rd_early_done: got %b want 0", rd_done); end
        rvalid = 1'b1; rlast = 1'b1; rdata = beat; rresp = resp;
        #1;
        n_vec++;
        if (rd_done !== oh) begin n_err++; $display("FAIL rd_done: got %b want %b", rd_done, oh); end
        n_vec++;
        if (rd_data !== d_exp) begin n_err++; $display("FAIL rd_data: got %h want %h", rd_data, d_exp); end
        n_vec++;
        if (rd_err !== (resp != 2'b00)) begin
            n_err++; $display("FAIL rd_err: got %b want %b", rd_err, resp != 2'b00);
        end
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0;
        n_vec++;
        if (rready !== 1'b0 || rd_done !== '0) begin
            n_err++; $display("FAIL rd_back_idle: rready=%b rd_done=%b want 0/0", rready, rd_done);
        end
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] resp);
        int n;
        int last;
        logic [63:0] wd_exp;
        logic [7:0] ws_exp;
        wd_exp = model_wdata(addr, data);
        ws_exp = model_wstrb(addr, strb);
        wr_valid = 1'b1; wr_addr = addr; wr_data = data; wr_strb = strb;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (awvalid !== 1'b1 && n < 50);
        n_vec++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            n_err++; $display("FAIL wr_start: awvalid=%b wvalid=%b want 1/1", awvalid, wvalid); return;
        end
        n_vec++;
        if (awaddr !== addr || awsize !== model_size(strb)) begin
            n_err++; $display("FAIL wr_aw: got %h/%0d want %h/%0d", awaddr, awsize, addr, model_size(strb));
        end
        n_vec++;
        if ({awid, awlen, awburst, wlast} !== {4'h0, 8'h00, 2'b01, 1'b1}) begin
            n_err++; $display("FAIL wr_fixed_fields: id=%0d len=%0d burst=%b wlast=%b want 0/0/01/1",
                              awid, awlen, awburst, wlast);
        end
        n_vec++;
        if (wdata !== wd_exp) begin n_err++; $display("FAIL wr_wdata: got %h want %h", wdata, wd_exp); end
        n_vec++;
        if (wstrb !== ws_exp) begin n_err++; $display("FAIL wr_wstrb: got %h want %h", wstrb, ws_exp); end
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        for (int c = 0; c <= last; c++) begin
            n_vec++;
            if (awvalid !== (c <= aw_dly) || wvalid !== (c <= w_dly)) begin
                n_err++; $display("FAIL wr_valid_track c=%0d: awvalid=%b wvalid=%b want %b/%b",
                                  c, awvalid, wvalid, c <= aw_dly, c <= w_dly);
            end
            awready = (c == aw_dly);
            wready  = (c == w_dly);
            @(posedge clk); #1;
            awready = 1'b0; wready = 1'b0;
        end
        n_vec++;
        if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            n_err++; $display("FAIL wr_b_phase: bready=%b awvalid=%b wvalid=%b want 1/0/0", bready, awvalid, wvalid);
        end
        for (int i = 0; i < b_dly; i++) begin @(posedge clk); #1; end
        n_vec++;
        if (wr_done !== 1'b0) begin n_err++; $display("FAIL wr_early_done: got %b want 0", wr_done); end
        bvalid = 1'b1; bresp = resp;
        #1;
        n_vec++;
        if (wr_done !== 1'b1 || wr_err !== (resp != 2'b00)) begin
            n_err++; $display("FAIL wr_done: done=%b err=%b want 1/%b", wr_done, wr_err, resp != 2'b00);
        end
        wr_valid = 1'b0;
        @(posedge clk); #1;
        bvalid = 1'b0;
        n_vec++;
        if (wr_done !== 1'b0 || bready !== 1'b0) begin
            n_err++; $display("FAIL wr_single_pulse: done=%b bready=%b want 0/0", wr_done, bready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if ({arvalid, awvalid, wvalid, rready, bready, rd_done, wr_done, rd_err, wr_err} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %b want 0",
                              {arvalid, awvalid, wvalid, rready, bready, rd_done, wr_done, rd_err, wr_err});
        end
        rst = 1'b0;
        m_last = 0;
        @(posedge clk); #1;
        n_vec++;
        if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
            n_err++; $display("FAIL idle_after_reset: got %b want 00000", {arvalid, awvalid, wvalid, rready, bready});
        end
    endtask

    task automatic test_ifu_read();
        int lat;
        req_addr[0] = 32'h3000_0004; req_strb[0] = 8'h0f;
        rd_valid = 2'b01;
        run_read(2'b01, 0, 0, 64'h1122_3344_5566_7788, 2'b00, lat);
        rd_valid = '0;
        n_vec++;
        if (lat != 2) begin n_err++; $display("FAIL rd_min_latency: got %0d edges want 2", lat); end
    endtask

    task automatic test_lsu_read();
        int lat;
        req_addr[1] = 32'h8000_0003; req_strb[1] = 8'h01;
        rd_valid = 2'b10;
        run_read(2'b10, 1, 2, 64'h0102_0304_AABB_CCDD, 2'b00, lat);
        rd_valid = '0;
    endtask

    task automatic test_back_to_back();
        int lat;
        apply_reset();
        req_addr[0] = 32'h3000_0000; req_strb[0] = 8'h0f;
        req_addr[1] = 32'h8000_0010; req_strb[1] = 8'h0f;
        rd_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            run_read(2'b11, 0, 0, {$urandom, $urandom}, 2'b00, lat);
            n_vec++;
            if (lat != 2) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d want 2", k, lat); end
        end
        rd_valid = '0;
    endtask

    task automatic test_store();
        run_write(32'h8000_0006, 32'h0000_1234, 8'h03, 2, 0, 1, 2'b00);
        run_write(32'h8000_0000, 32'hDEAD_BEEF, 8'h0f, 0, 0, 0, 2'b00);
        run_write(32'h8000_0001, 32'h0000_00A5, 8'h01, 0, 3, 0, 2'b10);
    endtask

    task automatic test_rd_err();
        int lat;
        req_addr[1] = 32'h8000_0008; req_strb[1] = 8'h0f;
        rd_valid = 2'b10;
        run_read(2'b10, 0, 1, 64'hCAFE_F00D_0BAD_BEEF, 2'b10, lat);
        run_read(2'b10, 0, 0, 64'h0000_0000_1357_9BDF, 2'b00, lat);
        rd_valid = '0;
    endtask

    task automatic test_concurrent();
        int lat;
        req_addr[0] = 32'h3000_0102; req_strb[0] = 8'h03;
        rd_valid = 2'b01;
        fork
            run_read(2'b01, 2, 3, 64'h8877_6655_4433_2211, 2'b00, lat);
            run_write(32'h8000_0105, 32'h0000_00EE, 8'h01, 1, 1, 2, 2'b00);
        join
        rd_valid = '0;
    endtask

    task automatic test_random();
        int lat;
        int idx;
        for (int t = 0; t < 20; t++) begin
            idx = $urandom_range(0, NR - 1);
            req_addr[idx] = $urandom;
            req_strb[idx] = rand_strb();
            rd_valid = '0;
            rd_valid[idx] = 1'b1;
            run_read(rd_valid, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00, lat);
            rd_valid = '0;
        end
        for (int t = 0; t < 12; t++) begin
            run_write($urandom, $urandom, rand_strb(), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        req_addr[0] = 32'h3000_0020; req_strb[0] = 8'h0f;
        rd_valid = 2'b01;
        wr_valid = 1'b1; wr_addr = 32'h8000_0040; wr_data = 32'h5555_AAAA; wr_strb = 8'h0f;
        @(posedge clk); #1;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        n_vec++;
        if (rready !== 1'b1 || awvalid !== 1'b1 || wvalid !== 1'b1) begin
            n_err++; $display("FAIL mid_precond: rready=%b awvalid=%b wvalid=%b want 1/1/1", rready, awvalid, wvalid);
        end
        rst = 1'b1; rd_valid = '0; wr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 0;
        n_vec++;
        if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
            n_err++; $display("FAIL mid_reset_valids: got %b want 00000", {arvalid, awvalid, wvalid, rready, bready});
        end
        rvalid = 1'b1; rlast = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF; bvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_vec++;
            if (rd_done !== '0 || wr_done !== 1'b0) begin
                n_err++; $display("FAIL stale_resp[%0d]: rd_done=%b wr_done=%b want 0/0", k, rd_done, wr_done);
            end
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0;
        rd_valid = 2'b01;
        run_read(2'b01, 0, 0, 64'h0F0E_0D0C_0B0A_0908, 2'b00, lat);
        rd_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rd_valid = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        for (int i = 0; i < NR; i++) begin req_addr[i] = '0; req_strb[i] = '0; end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0; rlast = 1'b0; rid = '0;
        test_reset();
        test_ifu_read();
        test_lsu_read();
        test_back_to_back();
        test_store();
        test_rd_err();
        test_concurrent();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
